// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage BRAM controller with load stall, lane extraction and writeback register
// Ports: clk, rst (sync, active-low); execute bundle req_valid/ram_*/rd_*_i in;
// stall_o to upstream; bram_* to a single-port BRAM with READ_LATENCY (1..3) read latency;
// wb_* registered writeback bundle. Optional MISALIGN_TRAP_EN adds misalign_o.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
module mem_access_unit #(
  parameter int ADDR_W = `MEM_ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              ram_we,
  input  logic              ram_re,
  input  logic [ADDR_W-1:0] ram_wr_addr,
  input  logic [31:0]       ram_w_data,
  input  logic [3:0]        ram_wr_mask,
  input  logic              ram_r_sign_ext,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [31:0]       rd_data_i,
  output logic              stall_o,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              wb_valid,
  output logic              wb_rd_we,
  output logic [4:0]        wb_rd_addr,
  output logic [31:0]       wb_rd_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [3:0] l_mask;
  logic l_sext, l_rd_we;
  logic [4:0] l_rd_addr;
  logic idle_req, is_st, is_ld, is_mis, ld_go, ld_done;
  logic [15:0] half;
  logic [7:0] byte_v;
  logic [31:0] ld_data;
  always_comb begin
    idle_req = state == IDLE && req_valid;
    is_st = idle_req && ram_we;
    is_ld = idle_req && ram_re && !ram_we;
`ifdef MISALIGN_TRAP_EN
    is_mis = (is_st || is_ld) && ram_wr_mask == 4'b0000;
`else
    is_mis = 1'b0;
`endif
    ld_go = is_ld && !is_mis;
    ld_done = state == WAIT && cnt == 2'(READ_LATENCY - 1);
    state_n = ld_go ? WAIT : ld_done ? IDLE : state;
    bram_en = (is_st || is_ld) && !is_mis;
    bram_we = is_st && !is_mis ? ram_wr_mask : 4'b0000;
    bram_addr = ram_wr_addr;
    bram_wdata = ram_w_data;
    stall_o = state == WAIT || ld_go;
  end
  // Lane 0 sits in the top byte of the BRAM word, so lane order is reversed to get little-endian values.
  always_comb begin
    half = l_mask == 4'b1100 ? {bram_rdata[23:16], bram_rdata[31:24]} : {bram_rdata[7:0], bram_rdata[15:8]};
    byte_v = l_mask[3] ? bram_rdata[31:24] : l_mask[2] ? bram_rdata[23:16] : l_mask[1] ? bram_rdata[15:8] : bram_rdata[7:0];
    ld_data = l_mask == 4'b1111 ? {bram_rdata[7:0], bram_rdata[15:8], bram_rdata[23:16], bram_rdata[31:24]}
            : (l_mask == 4'b1100 || l_mask == 4'b0011) ? {{16{l_sext & half[15]}}, half}
            : (l_mask == 4'b1000 || l_mask == 4'b0100 || l_mask == 4'b0010 || l_mask == 4'b0001)
              ? {{24{l_sext & byte_v[7]}}, byte_v} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      wb_valid <= 1'b0;
      wb_rd_we <= 1'b0;
      wb_rd_addr <= 5'd0;
      wb_rd_data <= 32'h0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt + 2'd1 : 2'd0;
      wb_valid <= ld_done || (idle_req && !ld_go);
      if (ld_go) begin
        l_mask <= ram_wr_mask;
        l_sext <= ram_r_sign_ext;
        l_rd_we <= rd_we_i;
        l_rd_addr <= rd_addr_i;
      end
      if (ld_done) begin
        wb_rd_we <= l_rd_we;
        wb_rd_addr <= l_rd_addr;
        wb_rd_data <= ld_data;
      end else if (is_st || is_mis) begin
        wb_rd_we <= 1'b0;
      end else if (idle_req && !ram_re) begin
        wb_rd_we <= rd_we_i;
        wb_rd_addr <= rd_addr_i;
        wb_rd_data <= rd_data_i;
      end
    end
  end
`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) misalign_o <= rst && is_mis;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: checks mem_access_unit (READ_LATENCY 1 and 3) against a byte-level memory model
module tb_mem_access_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, req_valid, ram_we, ram_re, ram_r_sign_ext, rd_we_i, sel3;
  logic [7:0] ram_wr_addr;
  logic [31:0] ram_w_data, rd_data_i;
  logic [3:0] ram_wr_mask;
  logic [4:0] rd_addr_i;
  logic stall1, en1, wbv1, wbwe1, stall3, en3, wbv3, wbwe3;
  logic [3:0] we1, we3;
  logic [7:0] addr1, addr3;
  logic [31:0] wdata1, wdata3, rdata1, rdata3, wbdata1, wbdata3;
  logic [4:0] wbaddr1, wbaddr3;
`ifdef MISALIGN_TRAP_EN
  logic mis1, mis3, v_mis;
  assign v_mis = sel3 ? mis3 : mis1;
`endif
  logic v_stall, v_en, v_wbv, v_wbwe;
  logic [3:0] v_we;
  logic [7:0] v_addr;
  logic [31:0] v_wdata, v_wbdata;
  logic [4:0] v_wbaddr;
  assign v_stall = sel3 ? stall3 : stall1;
  assign v_en = sel3 ? en3 : en1;
  assign v_we = sel3 ? we3 : we1;
  assign v_addr = sel3 ? addr3 : addr1;
  assign v_wdata = sel3 ? wdata3 : wdata1;
  assign v_wbv = sel3 ? wbv3 : wbv1;
  assign v_wbwe = sel3 ? wbwe3 : wbwe1;
  assign v_wbaddr = sel3 ? wbaddr3 : wbaddr1;
  assign v_wbdata = sel3 ? wbdata3 : wbdata1;

  mem_access_unit #(.ADDR_W(8), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wr_addr(ram_wr_addr), .ram_w_data(ram_w_data), .ram_wr_mask(ram_wr_mask),
    .ram_r_sign_ext(ram_r_sign_ext), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .stall_o(stall1), .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_wdata(wdata1),
    .bram_rdata(rdata1), .wb_valid(wbv1), .wb_rd_we(wbwe1), .wb_rd_addr(wbaddr1), .wb_rd_data(wbdata1)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(mis1)
`endif
  );
  mem_access_unit #(.ADDR_W(8), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wr_addr(ram_wr_addr), .ram_w_data(ram_w_data), .ram_wr_mask(ram_wr_mask),
    .ram_r_sign_ext(ram_r_sign_ext), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .stall_o(stall3), .bram_en(en3), .bram_we(we3), .bram_addr(addr3), .bram_wdata(wdata3),
    .bram_rdata(rdata3), .wb_valid(wbv3), .wb_rd_we(wbwe3), .wb_rd_addr(wbaddr3), .wb_rd_data(wbdata3)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(mis3)
`endif
  );

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    if (en1) begin
      for (int i = 0; i < 4; i++) if (we1[i]) mem1[addr1][8*i +: 8] <= wdata1[8*i +: 8];
      rdata1 <= mem1[addr1];
    end
  end
  always @(posedge clk) begin
    if (en3) begin
      for (int j = 0; j < 4; j++) if (we3[j]) mem3[addr3][8*j +: 8] <= wdata3[8*j +: 8];
      p0 <= mem3[addr3];
    end
    p1 <= p0;
    p2 <= p1;
  end
  assign rdata3 = p2;

  int errs = 0, checks = 0;
  logic [7:0] ref_b [0:1023];
  logic [3:0] masks [0:6];

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [3:0] m, input logic s);
    logic [31:0] v;
    int k;
    v = 0;
    k = 0;
    if (!(m inside {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001})) return 32'h0;
    for (int o = 0; o < 4; o++)
      if (m[3-o]) begin
        v = v | (32'(ref_b[32'(a)*4+o]) << (8*k));
        k++;
      end
    if (s && k < 4 && v[8*k-1]) v = v | (32'hFFFFFFFF << (8*k));
    return v;
  endfunction

  task automatic req(input logic we, re, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic s, rw, input logic [4:0] rd, input logic [31:0] rdd);
    req_valid = 1; ram_we = we; ram_re = re; ram_wr_addr = a; ram_w_data = d; ram_wr_mask = m;
    ram_r_sign_ext = s; rd_we_i = rw; rd_addr_i = rd; rd_data_i = rdd;
  endtask

  task automatic idle_in();
    req_valid = 0; ram_we = 0; ram_re = 0;
  endtask

  task automatic settle();
    idle_in();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic do_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m, input string nm);
    @(negedge clk);
    req(1, 0, a, d, m, 0, 1, 5'd3, 32'h0);
    #1;
    checks++;
    if ({v_en, v_we, v_addr, v_wdata, v_stall} !== {1'b1, m, a, d, 1'b0}) begin
      errs++;
      $display("FAIL %s bram got en=%b we=%b a=%h d=%h st=%b expected en=1 we=%b a=%h d=%h st=0",
               nm, v_en, v_we, v_addr, v_wdata, v_stall, m, a, d);
    end
    for (int o = 0; o < 4; o++) if (m[3-o]) ref_b[32'(a)*4+o] = d[31-8*o -: 8];
    @(negedge clk);
    #1;
    checks++;
    if ({v_wbv, v_wbwe} !== 2'b10) begin
      errs++;
      $display("FAIL %s wb got valid=%b we=%b expected valid=1 we=0", nm, v_wbv, v_wbwe);
    end
    settle();
  endtask

  task automatic do_load(input logic [7:0] a, input logic [3:0] m, input logic s, input logic [4:0] rd,
                         input logic rw, input logic [31:0] exp, input string nm);
    int n, st, rl;
    rl = sel3 ? 3 : 1;
    @(negedge clk);
    req(0, 1, a, $urandom, m, s, rw, rd, $urandom);
    #1;
    checks++;
    if ({v_en, v_we, v_addr, v_stall} !== {1'b1, 4'b0, a, 1'b1}) begin
      errs++;
      $display("FAIL %s issue got en=%b we=%b a=%h st=%b expected en=1 we=0 a=%h st=1", nm, v_en, v_we, v_addr, v_stall, a);
    end
    @(negedge clk);
    idle_in();
    #1;
    n = 1;
    st = 1;
    while (v_wbv !== 1'b1 && n < 8) begin
      if (v_stall === 1'b1) st++;
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != rl + 1 || st != rl + 1 || v_stall !== 1'b0) begin
      errs++;
      $display("FAIL %s timing got wb_at=%0d stall_cycles=%0d stall_now=%b expected %0d %0d 0", nm, n, st, v_stall, rl + 1, rl + 1);
    end
    checks++;
    if ({v_wbwe, v_wbaddr, v_wbdata} !== {rw, rd, exp}) begin
      errs++;
      $display("FAIL %s data got we=%b rd=%0d d=%h expected we=%b rd=%0d d=%h", nm, v_wbwe, v_wbaddr, v_wbdata, rw, rd, exp);
    end
    settle();
  endtask

  task automatic do_alu(input logic rw, input logic [4:0] rd, input logic [31:0] d, input string nm);
    @(negedge clk);
    req(0, 0, 8'h0, 32'h0, 4'hF, 0, rw, rd, d);
    #1;
    checks++;
    if ({v_en, v_stall} !== 2'b00) begin
      errs++;
      $display("FAIL %s bram got en=%b st=%b expected 0 0", nm, v_en, v_stall);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if ({v_wbv, v_wbwe, v_wbaddr, v_wbdata} !== {1'b1, rw, rd, d}) begin
      errs++;
      $display("FAIL %s wb got v=%b we=%b rd=%0d d=%h expected 1 %b %0d %h", nm, v_wbv, v_wbwe, v_wbaddr, v_wbdata, rw, rd, d);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({v_wbv, v_wbwe, v_wbaddr, v_wbdata} !== {1'b0, rw, rd, d}) begin
      errs++;
      $display("FAIL %s idle_hold got v=%b we=%b rd=%0d d=%h expected 0 %b %0d %h", nm, v_wbv, v_wbwe, v_wbaddr, v_wbdata, rw, rd, d);
    end
    settle();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wbv1, wbwe1, wbaddr1, wbdata1, en1, we1, stall1, wbv3, stall3} !== '0) begin
      errs++;
      $display("FAIL reset got wb=%b%b/%0d/%h en=%b we=%b st=%b u3 v=%b st=%b expected all 0",
               wbv1, wbwe1, wbaddr1, wbdata1, en1, we1, stall1, wbv3, stall3);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if ({mis1, mis3} !== 2'b00) begin
      errs++;
      $display("FAIL reset_misalign got %b%b expected 00", mis1, mis3);
    end
`endif
    rst = 1;
  endtask

  task automatic test_store_load();
    sel3 = 0;
    for (int i = 0; i < 8; i++) do_store(8'(i), 32'h0, 4'hF, "init");
    do_store(8'h10, 32'h78563412, 4'hF, "sw");
    do_load(8'h10, 4'hF, 0, 5'd5, 1, 32'h12345678, "lw");
  endtask

  task automatic test_byte_half();
    sel3 = 0;
    do_store(8'h20, 32'h00008000, 4'hF, "sw_b");
    do_load(8'h20, 4'b0010, 1, 5'd6, 1, 32'hFFFFFF80, "lb");
    do_load(8'h20, 4'b0010, 0, 5'd6, 1, 32'h00000080, "lbu");
    do_store(8'h21, 32'h000034F2, 4'hF, "sw_h");
    do_load(8'h21, 4'b0011, 1, 5'd7, 1, 32'hFFFFF234, "lh");
    do_store(8'h22, 32'h9A00BC00, 4'b1010, "sb_pair");
    do_load(8'h22, 4'b1100, 0, 5'd8, 0, ref_load(8'h22, 4'b1100, 0), "lhu_hi");
    do_load(8'h22, 4'b1000, 1, 5'd9, 1, ref_load(8'h22, 4'b1000, 1), "lb_hi");
  endtask

  task automatic test_back_to_back();
    int lk, ak, pulses;
    logic held, acc;
    logic [31:0] exp;
    exp = ref_load(8'h10, 4'hF, 0);
    @(negedge clk);
    req(0, 1, 8'h10, 32'h0, 4'hF, 0, 1, 5'd7, 32'h0);
    @(negedge clk);
    req(0, 0, 8'h0, 32'h0, 4'hF, 0, 1, 5'd9, 32'h0000DEAD);
    #1;
    lk = -1; ak = -1; pulses = 0; held = 1;
    for (int k = 1; k < 10; k++) begin
      if (v_wbv === 1'b1) begin
        pulses++;
        if (lk < 0) begin
          lk = k;
          checks++;
          if ({v_wbaddr, v_wbdata} !== {5'd7, exp}) begin
            errs++;
            $display("FAIL b2b_load got rd=%0d d=%h expected 7 %h", v_wbaddr, v_wbdata, exp);
          end
        end else if (ak < 0) begin
          ak = k;
          checks++;
          if ({v_wbwe, v_wbaddr, v_wbdata} !== {1'b1, 5'd9, 32'h0000DEAD}) begin
            errs++;
            $display("FAIL b2b_alu got we=%b rd=%0d d=%h expected 1 9 0000dead", v_wbwe, v_wbaddr, v_wbdata);
          end
        end
      end
      acc = held && v_stall === 1'b0;
      @(negedge clk);
      if (acc) begin
        idle_in();
        held = 0;
      end
      #1;
    end
    checks++;
    if (lk != (sel3 ? 4 : 2) || ak != lk + 1 || pulses != 2) begin
      errs++;
      $display("FAIL b2b_order got load_at=%0d alu_at=%0d pulses=%0d expected %0d %0d 2", lk, ak, pulses, sel3 ? 4 : 2, (sel3 ? 4 : 2) + 1);
    end
    settle();
  endtask

  task automatic test_latency3();
    sel3 = 1;
    do_load(8'h10, 4'hF, 0, 5'd5, 1, 32'h12345678, "lw_rl3");
    do_load(8'h21, 4'b0011, 1, 5'd4, 1, 32'hFFFFF234, "lh_rl3");
    test_back_to_back();
    sel3 = 0;
  endtask

  task automatic test_mask0();
    sel3 = 0;
`ifdef MISALIGN_TRAP_EN
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req(t == 0, t == 1, 8'h10, 32'hFFFFFFFF, 4'b0000, 0, 1, 5'd2, 32'h0);
      #1;
      checks++;
      if ({en1, stall1} !== 2'b00) begin
        errs++;
        $display("FAIL mis_issue%0d got en=%b st=%b expected 0 0", t, en1, stall1);
      end
      @(negedge clk);
      idle_in();
      #1;
      checks++;
      if ({mis1, wbv1, wbwe1} !== 3'b110) begin
        errs++;
        $display("FAIL mis_pulse%0d got mis=%b v=%b we=%b expected 1 1 0", t, mis1, wbv1, wbwe1);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({mis1, wbv1} !== 2'b00) begin
        errs++;
        $display("FAIL mis_once%0d got mis=%b v=%b expected 0 0", t, mis1, wbv1);
      end
      settle();
    end
`else
    do_store(8'h10, 32'hFFFFFFFF, 4'b0000, "sw_mask0");
    do_load(8'h10, 4'hF, 0, 5'd5, 1, 32'h12345678, "lw_after_mask0");
    do_load(8'h10, 4'b0000, 1, 5'd11, 1, 32'h0, "ld_mask0");
`endif
  endtask

  task automatic test_reset_mid_load();
    int p;
    sel3 = 0;
    @(negedge clk);
    req(0, 1, 8'h10, 32'h0, 4'hF, 0, 1, 5'd12, 32'h0);
    @(negedge clk);
    idle_in();
    rst = 0;
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({stall1, wbv1, stall3, wbv3} !== 4'b0000) begin
      errs++;
      $display("FAIL rst_mid got st=%b v=%b u3 st=%b v=%b expected 0", stall1, wbv1, stall3, wbv3);
    end
    p = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (wbv1 === 1'b1 || wbv3 === 1'b1) p++;
    end
    checks++;
    if (p != 0) begin
      errs++;
      $display("FAIL rst_drop got wb_pulses=%0d expected 0", p);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [3:0] m;
    logic s;
    logic [4:0] rd;
    for (int i = 0; i < 40; i++) begin
      sel3 = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 7));
      m = masks[$urandom_range(0, 6)];
      s = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: do_store(a, $urandom, m, "rand_st");
        1: do_load(a, m, s, rd, 1, ref_load(a, m, s), "rand_ld");
        default: do_alu(s, rd, $urandom, "rand_alu");
      endcase
    end
    sel3 = 0;
  endtask

  initial begin
    masks[0] = 4'b1111; masks[1] = 4'b1100; masks[2] = 4'b0011; masks[3] = 4'b1000;
    masks[4] = 4'b0100; masks[5] = 4'b0010; masks[6] = 4'b0001;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    rst = 0;
    sel3 = 0;
    idle_in();
    ram_wr_addr = 0; ram_w_data = 0; ram_wr_mask = 0; ram_r_sign_ext = 0;
    rd_we_i = 0; rd_addr_i = 0; rd_data_i = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_store_load();
    test_byte_half();
    do_alu(1, 5'd13, 32'hCAFEF00D, "alu");
    test_back_to_back();
    test_latency3();
    test_mask0();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory controller. It consumes the execute stage's memory request bundle: ram_we/ram_re, word address, big-lane-ordered write data, byte mask, sign-extend flag and rd info.
- It drives a single-port BRAM with configurable read latency and stalls the pipeline while a load is outstanding.
- It turns the BRAM word back into a little-endian, sign- or zero-extended rd value and presents it to writeback.
- Non-memory results pass through with one register stage.

Parameters:
- ADDR_W, default `MEM_ADDR_WIDTH: BRAM word-address width.
- READ_LATENCY, default 1: cycles from bram_en to valid bram_rdata. Legal range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  execute-stage bundle valid this cycle
- ram_we  in  1  store request
- ram_re  in  1  load request
- ram_wr_addr  in  ADDR_W  word address
- ram_w_data  in  32  store data, lane layout: bits[31:24]=byte offset 0 … bits[7:0]=byte offset 3
- ram_wr_mask  in  4  byte-lane mask: bit3=offset 0 … bit0=offset 3
- ram_r_sign_ext  in  1  sign-extend loaded byte/half
- rd_we_i  in  1  writeback enable
- rd_addr_i  in  5  destination register
- rd_data_i  in  32  ALU result for non-load instructions
- stall_o  out  1  hold upstream stages
- bram_en  out  1  BRAM enable
- bram_we  out  4  BRAM byte write enables (same lane order as the mask)
- bram_addr  out  ADDR_W  BRAM address
- bram_wdata  out  32  BRAM write data
- bram_rdata  in  32  BRAM read data, same lane layout
- wb_valid  out  1  writeback bundle valid (1-cycle pulse)
- wb_rd_we  out  1  writeback enable
- wb_rd_addr  out  5  writeback register
- wb_rd_data  out  32  writeback data

Behaviour:
- Reset (rst=0 at a clk edge):
  - state←IDLE, latency counter←0.
  - wb_valid, wb_rd_we, wb_rd_addr and wb_rd_data all ←0.
  - A pending load is dropped; no writeback is produced for it.
  - The combinational outputs bram_en, bram_we and stall_o are 0 while in IDLE with req_valid=0.
- States:
  - IDLE: accepts a request when req_valid=1.
  - WAIT: counting READ_LATENCY cycles.
  - Both WAIT exits return to IDLE.
- Request priority: ram_we && ram_re together is illegal and is treated as a store.
- Store accepted in IDLE at cycle T:
  - During T: bram_en=1, bram_we=ram_wr_mask, bram_addr=ram_wr_addr, bram_wdata=ram_w_data pass through unchanged.
  - Cycle T+1: wb_valid=1, wb_rd_we=0.
  - No stall; state stays IDLE.
- Load accepted in IDLE at cycle T:
  - During T: bram_en=1, bram_we=0, bram_addr=ram_wr_addr.
  - Latched at the T edge: mask, sign_ext, rd_we_i, rd_addr_i.
  - State→WAIT.
  - Data is sampled from bram_rdata in cycle T+READ_LATENCY and registered at the end of that cycle.
  - Cycle T+READ_LATENCY+1: wb_valid=1, state=IDLE.
- stall_o = (state==WAIT) || (req_valid && ram_re && !ram_we && state==IDLE).
  - With READ_LATENCY=1, stall_o is high in T and T+1 and low in T+2.
  - Upstream holds its bundle while stalled. The held bundle is not re-accepted until IDLE; the first IDLE cycle after a load accepts the next request.
- Non-memory request (req_valid, !ram_we, !ram_re) at T:
  - Cycle T+1: wb_valid=1, wb_rd_we=rd_we_i, wb_rd_addr=rd_addr_i, wb_rd_data=rd_data_i.
- req_valid=0 in IDLE: wb_valid=0 next cycle; the other wb_* outputs hold their values.
- Load data extraction (r=bram_rdata):
  - Mask 1111: {r[7:0],r[15:8],r[23:16],r[31:24]}.
  - Mask 1100: half={r[23:16],r[31:24]}.
  - Mask 0011: half={r[7:0],r[15:8]}.
  - Mask 1000 / 0100 / 0010 / 0001: byte = r[31:24] / r[23:16] / r[15:8] / r[7:0].
  - Half and byte are sign-extended when sign_ext=1, else zero-extended.
- Mask 0000 (misaligned access): handling is defined under Optional Feature.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A load or store with mask 0000 issues no BRAM access (bram_en=0) and does not stall.
  - Next cycle: misalign_o=1 for one cycle, wb_valid=1, wb_rd_we=0.
- Undefined:
  - A store with mask 0000 issues bram_en=1, bram_we=0 (no-op).
  - A load with mask 0000 runs the normal load sequence and writes wb_rd_data=0 with wb_rd_we as latched.

Test Plan:
- Store SW: word 0x10, ram_w_data=0x78563412, mask 1111, then LW word 0x10 rd=5 → stall_o high 2 cycles; wb_valid at T+2; wb_rd_data=0x12345678, wb_rd_addr=5.
- LB, sign_ext=1: mask 0010, word byte r[15:8]=0x80 → wb_rd_data=0xFFFFFF80. LBU, same byte → 0x00000080.
- LH, mask 0011, r[15:0]=0x34F2, sign_ext=1 → half={0xF2,0x34}=0xF234 → wb_rd_data=0xFFFFF234.
- Back-to-back: load, then an ALU op with rd_data_i=0xDEAD held during the stall → ALU result appears exactly one cycle after the load's wb_valid; no duplicate writeback.
- READ_LATENCY=3: LW → stall_o high 4 cycles; wb_valid at T+4 with data sampled in T+3.
- rst=0 in the cycle after a load is accepted → next cycle state IDLE, stall_o=0, wb_valid never asserts for that load. With MISALIGN_TRAP_EN, a mask 0000 store → bram_en=0 and misalign_o pulses once.
